// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the MIPS 5-stage hazard/forwarding controller.
package mips_pipe_pkg;

  // Shadow entries carry indices this wide; the top zero-extends REG_AW-bit indices into them.
  localparam int RIDX_W = 8;
  localparam int NSTG   = 3;
  localparam int ST_EX  = 0;
  localparam int ST_M   = 1;
  localparam int ST_WB  = 2;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef struct packed {
    logic              valid;
    logic [RIDX_W-1:0] rd;
    logic              regwrite;
    logic              memread;
    logic [RIDX_W-1:0] rs;
    logic [RIDX_W-1:0] rt;
    logic              use_rs;
    logic              use_rt;
  } stage_entry_t;

  function automatic bit branch_stage_ok(int s);
    return (s >= 1) && (s <= 3);
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// ID-stage hazard inputs and pipeline-control outputs of the hazard controller.
interface pipeline_hazard_ctrl_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
);
  logic              id_valid;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic              id_use_rs;
  logic              id_use_rt;
  logic [REG_AW-1:0] id_rd;
  logic              id_regwrite;
  logic              id_memread;
  logic              redirect;
  logic              pc_we;
  logic              if_id_we;
  logic              if_id_flush;
  logic              id_ex_flush;
  logic              ex_m_flush;
  logic [1:0]        fwd_a;
  logic [1:0]        fwd_b;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  modport master (
    output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_rd, id_regwrite, id_memread, redirect,
    input  pc_we, if_id_we, if_id_flush, id_ex_flush, ex_m_flush, fwd_a, fwd_b, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_rd, id_regwrite, id_memread, redirect,
    output pc_we, if_id_we, if_id_flush, id_ex_flush, ex_m_flush, fwd_a, fwd_b, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipeline_hazard_ctrl_shadow.sv
// One shadow pipeline entry: loads the older stage's entry, or a bubble on stall/flush.
module hazard_shadow_stage
  import mips_pipe_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         bubble,
  input  logic         flush,
  input  stage_entry_t d,
  output stage_entry_t q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)              q <= '0;
    else if (bubble | flush) q <= '0;
    else                     q <= d;
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/forwarding controller: shadow EX/M/WB destination tracking, EX forwarding
// selects, load-use/RAW stalls, redirect flushes and saturating stall/flush counters.
module pipeline_hazard_ctrl
  import mips_pipe_pkg::*;
#(
  parameter int REG_AW       = 5,
  parameter int BRANCH_STAGE = 3,
  parameter int FWD_ENABLE   = 1,
  parameter int RF_WT        = 1,
  parameter int CNT_W        = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  pipeline_hazard_ctrl_if.slave  bus
);

  if (!branch_stage_ok(BRANCH_STAGE)) begin : g_bad_branch_stage
    $error("pipeline_hazard_ctrl: BRANCH_STAGE must be 1, 2 or 3");
  end
  if (REG_AW > RIDX_W) begin : g_bad_reg_aw
    $error("pipeline_hazard_ctrl: REG_AW exceeds shadow index width");
  end

  localparam bit FWD_ON = (FWD_ENABLE != 0);
  // Stages whose pending write blocks an ID read: EX loads only when forwarding,
  // otherwise everything not yet visible in the register file.
  localparam logic [NSTG-1:0] STALL_MASK = FWD_ON ? 3'b001 : ((RF_WT != 0) ? 3'b011 : 3'b111);

  stage_entry_t      d [NSTG];
  stage_entry_t      q [NSTG];
  logic [NSTG-1:0]   bubble, flush;
  logic [NSTG-1:0]   live, hit_rs, hit_rt;
  logic [NSTG-1:1]   hit_ea, hit_eb;
  logic [RIDX_W-1:0] rs_x, rt_x;
  logic              redir, ld_gate, src_rs, src_rt, stall;
  logic              fwd_ok_a, fwd_ok_b;
  logic [CNT_W-1:0]  stall_cnt, flush_cnt;

  // Gate redirect with reset so flushes read 0 while reset is held.
  assign redir = bus.redirect & reset;
  assign rs_x  = RIDX_W'(bus.id_rs);
  assign rt_x  = RIDX_W'(bus.id_rt);

  always_comb begin
    d[ST_EX]          = '0;
    d[ST_EX].valid    = bus.id_valid;
    d[ST_EX].rd       = RIDX_W'(bus.id_rd);
    d[ST_EX].regwrite = bus.id_regwrite;
    d[ST_EX].memread  = bus.id_memread;
    d[ST_EX].rs       = rs_x;
    d[ST_EX].rt       = rt_x;
    d[ST_EX].use_rs   = bus.id_use_rs;
    d[ST_EX].use_rt   = bus.id_use_rt;
  end
  assign d[ST_M]  = q[ST_EX];
  assign d[ST_WB] = q[ST_M];

  assign bubble = {1'b0, 1'b0, stall};
  assign flush  = {1'b0, redir & (BRANCH_STAGE == 3), redir & (BRANCH_STAGE >= 2)};

  for (genvar i = 0; i < NSTG; i++) begin : g_stg
    hazard_shadow_stage u_stg (
      .clk    (clk),
      .reset  (reset),
      .bubble (bubble[i]),
      .flush  (flush[i]),
      .d      (d[i]),
      .q      (q[i])
    );
    assign live[i]   = q[i].valid & q[i].regwrite & (q[i].rd != '0);
    assign hit_rs[i] = live[i] & (q[i].rd == rs_x);
    assign hit_rt[i] = live[i] & (q[i].rd == rt_x);
  end

  for (genvar i = 1; i < NSTG; i++) begin : g_fwd_hit
    assign hit_ea[i] = live[i] & (q[i].rd == q[ST_EX].rs);
    assign hit_eb[i] = live[i] & (q[i].rd == q[ST_EX].rt);
  end

  assign ld_gate = FWD_ON ? q[ST_EX].memread : 1'b1;
  assign src_rs  = ld_gate & (|(hit_rs & STALL_MASK));
  assign src_rt  = ld_gate & (|(hit_rt & STALL_MASK));
  assign stall   = bus.id_valid & ((bus.id_use_rs & src_rs) | (bus.id_use_rt & src_rt)) & ~redir;

  assign bus.pc_we       = ~stall;
  assign bus.if_id_we    = ~stall;
  assign bus.if_id_flush = redir;
  assign bus.id_ex_flush = stall | (redir & (BRANCH_STAGE >= 2));
  assign bus.ex_m_flush  = redir & (BRANCH_STAGE == 3);

  // M is the younger producer, so it wins over WB.
  assign fwd_ok_a  = FWD_ON & q[ST_EX].valid & q[ST_EX].use_rs;
  assign fwd_ok_b  = FWD_ON & q[ST_EX].valid & q[ST_EX].use_rt;
  assign bus.fwd_a = !fwd_ok_a ? FWD_REG : hit_ea[ST_M] ? FWD_MEM : hit_ea[ST_WB] ? FWD_WB : FWD_REG;
  assign bus.fwd_b = !fwd_ok_b ? FWD_REG : hit_eb[ST_M] ? FWD_MEM : hit_eb[ST_WB] ? FWD_WB : FWD_REG;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
      if (redir && flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
    end
  end

  assign bus.stall_cnt = stall_cnt;
  assign bus.flush_cnt = flush_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Four controller configurations share one ID stimulus stream; each is checked per cycle
// against an instruction-level model of what is in flight behind ID.
module tb_pipeline_hazard_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic       id_valid, id_use_rs, id_use_rt, id_regwrite, id_memread, redirect;
  logic [4:0] id_rs, id_rt, id_rd;

  pipeline_hazard_ctrl_if #(.REG_AW(5), .CNT_W(16)) if0 ();
  pipeline_hazard_ctrl_if #(.REG_AW(5), .CNT_W(16)) if1 ();
  pipeline_hazard_ctrl_if #(.REG_AW(5), .CNT_W(4))  if2 ();
  pipeline_hazard_ctrl_if #(.REG_AW(5), .CNT_W(4))  if3 ();

  pipeline_hazard_ctrl #(.REG_AW(5), .BRANCH_STAGE(3), .FWD_ENABLE(1), .RF_WT(1), .CNT_W(16))
    u_dut0 (.clk(clk), .reset(reset), .bus(if0));
  pipeline_hazard_ctrl #(.REG_AW(5), .BRANCH_STAGE(1), .FWD_ENABLE(1), .RF_WT(1), .CNT_W(16))
    u_dut1 (.clk(clk), .reset(reset), .bus(if1));
  pipeline_hazard_ctrl #(.REG_AW(5), .BRANCH_STAGE(2), .FWD_ENABLE(0), .RF_WT(0), .CNT_W(4))
    u_dut2 (.clk(clk), .reset(reset), .bus(if2));
  pipeline_hazard_ctrl #(.REG_AW(5), .BRANCH_STAGE(1), .FWD_ENABLE(0), .RF_WT(1), .CNT_W(4))
    u_dut3 (.clk(clk), .reset(reset), .bus(if3));

  assign {if0.id_valid, if0.id_rs, if0.id_rt, if0.id_use_rs, if0.id_use_rt, if0.id_rd, if0.id_regwrite, if0.id_memread, if0.redirect} =
         {id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_rd, id_regwrite, id_memread, redirect};
  assign {if1.id_valid, if1.id_rs, if1.id_rt, if1.id_use_rs, if1.id_use_rt, if1.id_rd, if1.id_regwrite, if1.id_memread, if1.redirect} =
         {id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_rd, id_regwrite, id_memread, redirect};
  assign {if2.id_valid, if2.id_rs, if2.id_rt, if2.id_use_rs, if2.id_use_rt, if2.id_rd, if2.id_regwrite, if2.id_memread, if2.redirect} =
         {id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_rd, id_regwrite, id_memread, redirect};
  assign {if3.id_valid, if3.id_rs, if3.id_rt, if3.id_use_rs, if3.id_use_rt, if3.id_rd, if3.id_regwrite, if3.id_memread, if3.redirect} =
         {id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_rd, id_regwrite, id_memread, redirect};

  // {pc_we, if_id_we, if_id_flush, id_ex_flush, ex_m_flush}
  logic [4:0]  ctl_o [4];
  logic [3:0]  fwd_o [4];
  logic [15:0] scnt_o [4];
  logic [15:0] fcnt_o [4];
  assign ctl_o[0] = {if0.pc_we, if0.if_id_we, if0.if_id_flush, if0.id_ex_flush, if0.ex_m_flush};
  assign ctl_o[1] = {if1.pc_we, if1.if_id_we, if1.if_id_flush, if1.id_ex_flush, if1.ex_m_flush};
  assign ctl_o[2] = {if2.pc_we, if2.if_id_we, if2.if_id_flush, if2.id_ex_flush, if2.ex_m_flush};
  assign ctl_o[3] = {if3.pc_we, if3.if_id_we, if3.if_id_flush, if3.id_ex_flush, if3.ex_m_flush};
  assign fwd_o[0] = {if0.fwd_a, if0.fwd_b};
  assign fwd_o[1] = {if1.fwd_a, if1.fwd_b};
  assign fwd_o[2] = {if2.fwd_a, if2.fwd_b};
  assign fwd_o[3] = {if3.fwd_a, if3.fwd_b};
  assign scnt_o[0] = if0.stall_cnt;
  assign scnt_o[1] = if1.stall_cnt;
  assign scnt_o[2] = 16'(if2.stall_cnt);
  assign scnt_o[3] = 16'(if3.stall_cnt);
  assign fcnt_o[0] = if0.flush_cnt;
  assign fcnt_o[1] = if1.flush_cnt;
  assign fcnt_o[2] = 16'(if2.flush_cnt);
  assign fcnt_o[3] = 16'(if3.flush_cnt);

  localparam int BS_C   [4] = '{3, 1, 2, 1};
  localparam int FWD_C  [4] = '{1, 1, 0, 0};
  localparam int RFWT_C [4] = '{1, 1, 0, 1};
  localparam int CMAX_C [4] = '{65535, 65535, 15, 15};

  // One in-flight instruction as seen from ID; index 0 = next older (EX), 1 = M, 2 = WB.
  typedef struct {
    bit v;
    bit wr;
    bit ld;
    bit urs;
    bit urt;
    int rs;
    int rt;
    int rd;
  } ins_t;

  ins_t pipe [4][3];
  int   m_scnt [4];
  int   m_fcnt [4];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic ins_t no_ins();
    ins_t e;
    e.v = 0; e.wr = 0; e.ld = 0; e.urs = 0; e.urt = 0; e.rs = 0; e.rt = 0; e.rd = 0;
    return e;
  endfunction

  function automatic bit writes(int k, int pos, int r);
    return pipe[k][pos].v && pipe[k][pos].wr && r != 0 && pipe[k][pos].rd == r;
  endfunction

  // ID cannot read r yet: with forwarding only a load directly ahead blocks it;
  // without, any producer whose result has not reached the register file.
  function automatic bit blocked(int k, int r);
    if (FWD_C[k] != 0) return writes(k, 0, r) && pipe[k][0].ld;
    for (int p = 0; p < ((RFWT_C[k] != 0) ? 2 : 3); p++)
      if (writes(k, p, r)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int src_sel(int k, bit used, int r);
    if (FWD_C[k] == 0 || !pipe[k][0].v || !used) return 0;
    if (writes(k, 1, r)) return 2;
    if (writes(k, 2, r)) return 1;
    return 0;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 4; k++) begin
      for (int p = 0; p < 3; p++) pipe[k][p] = no_ins();
      m_scnt[k] = 0;
      m_fcnt[k] = 0;
    end
  endtask

  task automatic drive(bit v, int rs, int rt, bit urs, bit urt, int rd, bit wr, bit ld, bit rdr);
    id_valid = v; id_rs = 5'(rs); id_rt = 5'(rt); id_use_rs = urs; id_use_rt = urt;
    id_rd = 5'(rd); id_regwrite = wr; id_memread = ld; redirect = rdr;
  endtask

  task automatic nop();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Called just after a falling edge with inputs set; checks every DUT, then advances the model.
  task automatic step();
    #2;
    for (int k = 0; k < 4; k++) begin
      ins_t       cur;
      bit         st;
      logic [4:0] ectl;
      logic [3:0] efwd;
      cur.v = id_valid; cur.wr = id_regwrite; cur.ld = id_memread; cur.urs = id_use_rs;
      cur.urt = id_use_rt; cur.rs = int'(id_rs); cur.rt = int'(id_rt); cur.rd = int'(id_rd);
      st = id_valid && ((id_use_rs && blocked(k, cur.rs)) || (id_use_rt && blocked(k, cur.rt))) && !redirect;
      ectl = {!st, !st, redirect, st || (redirect && BS_C[k] >= 2), redirect && BS_C[k] == 3};
      efwd = {2'(src_sel(k, pipe[k][0].urs, pipe[k][0].rs)), 2'(src_sel(k, pipe[k][0].urt, pipe[k][0].rt))};
      chk($sformatf("d%0d_ctl", k), 32'(ctl_o[k]), 32'(ectl));
      chk($sformatf("d%0d_fwd", k), 32'(fwd_o[k]), 32'(efwd));
      chk($sformatf("d%0d_stall_cnt", k), 32'(scnt_o[k]), 32'(m_scnt[k]));
      chk($sformatf("d%0d_flush_cnt", k), 32'(fcnt_o[k]), 32'(m_fcnt[k]));
      pipe[k][2] = pipe[k][1];
      pipe[k][1] = (redirect && BS_C[k] == 3) ? no_ins() : pipe[k][0];
      pipe[k][0] = (st || (redirect && BS_C[k] >= 2)) ? no_ins() : cur;
      if (st && m_scnt[k] < CMAX_C[k]) m_scnt[k]++;
      if (redirect && m_fcnt[k] < CMAX_C[k]) m_fcnt[k]++;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    nop();
    #1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("d%0d_rst_ctl", k), 32'(ctl_o[k]), 32'h18);
      chk($sformatf("d%0d_rst_fwd", k), 32'(fwd_o[k]), 32'h0);
      chk($sformatf("d%0d_rst_cnt", k), {scnt_o[k], fcnt_o[k]}, 32'h0);
    end
    model_clear();
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    model_clear();

    // add $3,$1,$2 ; sub $4,$3,$1 ; add $5,$3,$0
    do_reset();
    drive(1, 1, 2, 1, 1, 3, 1, 0, 0); step();
    drive(1, 3, 1, 1, 1, 4, 1, 0, 0); step();
    drive(1, 3, 0, 1, 1, 5, 1, 0, 0);
    #1 chk("s1_fwd_a_mem", 32'(if0.fwd_a), 32'd2);
    chk("s1_no_stall", 32'(if0.pc_we), 32'd1);
    step();
    nop();
    #1 chk("s1_fwd_a_wb", 32'(if0.fwd_a), 32'd1);
    step();

    // lw $2,0($1) ; add $3,$2,$2
    do_reset();
    drive(1, 1, 2, 1, 0, 2, 1, 1, 0); step();
    drive(1, 2, 2, 1, 1, 3, 1, 0, 0);
    #1 chk("s2_load_use", 32'(ctl_o[0]), 32'h02);
    step();
    drive(1, 2, 2, 1, 1, 3, 1, 0, 0);
    #1 chk("s2_released", 32'(ctl_o[0]), 32'h18);
    step();
    nop();
    #1 chk("s2_fwd_wb", 32'(fwd_o[0]), 32'h5);
    chk("s2_stall_cnt", 32'(scnt_o[0]), 32'd1);
    step();

    // write $0 then read $0
    do_reset();
    drive(1, 1, 2, 1, 1, 0, 1, 0, 0); step();
    drive(1, 0, 0, 1, 1, 4, 1, 0, 0);
    #1 chk("s3_r0_nofwd", 32'(ctl_o[2]), 32'h18);
    chk("s3_r0_fwd", 32'(ctl_o[0]), 32'h18);
    step();
    nop();
    #1 chk("s3_r0_sel", 32'(fwd_o[0]), 32'h0);
    step();

    // taken branch
    do_reset();
    drive(1, 1, 2, 1, 1, 0, 0, 0, 1);
    #1 chk("s4_bs3_flush", 32'(ctl_o[0]), 32'h1f);
    chk("s4_bs1_flush", 32'(ctl_o[1]), 32'h1c);
    step();
    nop();
    #1 chk("s4_flush_cnt", 32'(fcnt_o[0]), 32'd1);
    step();

    // load-use coinciding with redirect
    do_reset();
    drive(1, 1, 2, 1, 0, 2, 1, 1, 0); step();
    drive(1, 2, 2, 1, 1, 3, 1, 0, 1);
    #1 chk("s5_redirect_wins", 32'(ctl_o[0]), 32'h1f);
    step();
    nop();
    #1 chk("s5_stall_cnt", 32'(scnt_o[0]), 32'd0);
    step();

    // reset asserted mid-stall
    do_reset();
    drive(1, 1, 2, 1, 0, 2, 1, 1, 0); step();
    drive(1, 2, 2, 1, 1, 3, 1, 0, 0);
    #1 chk("s6_stalling", 32'(if0.pc_we), 32'd0);
    reset = 1'b0;
    #1 chk("s6_rst_pc_we", 32'(ctl_o[0]), 32'h18);
    model_clear();
    @(negedge clk);
    reset = 1'b1;
    drive(1, 2, 2, 1, 1, 3, 1, 0, 0); step();

    // self-dependent chain: no-forward configs stall repeatedly, 4-bit counters saturate
    do_reset();
    repeat (40) begin
      drive(1, 7, 7, 1, 1, 7, 1, 0, 0);
      step();
    end
    chk("s7_sat_d2", 32'(scnt_o[2]), 32'd15);
    chk("s7_fwd_no_stall", 32'(scnt_o[0]), 32'd0);

    // random traffic over a small register set to keep hazards frequent
    do_reset();
    repeat (600) begin
      drive($urandom_range(0, 99) < 85, $urandom_range(0, 7), $urandom_range(0, 7),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 7),
            1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
